// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 key matrix scanner with image debounce and key events
//
// Drives one matrix column at a time (with a blank gap between columns), samples the
// synchronized rows at the end of each drive phase, debounces complete 16-bit images
// and reports single-key presses as one-cycle events.
//
// Ports:
//   Clk       in   1  system clock, posedge
//   nReset    in   1  asynchronous active-low reset
//   RowIn     in   4  matrix rows, 1 = pressed on the driven column (asynchronous)
//   ColOut    out  4  one-hot column drive, 4'b0000 during blank phases
//   KeyValid  out  1  one-cycle pulse on a newly accepted single-key press
//   KeyCode   out  4  {col, row} of the last accepted key, held between events
//   KeyHeld   out  1  high while the debounced image is non-zero

module keypad_matrix_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [3:0] RowIn,
    output logic [3:0] ColOut,
    output logic       KeyValid,
    output logic [3:0] KeyCode,
    output logic       KeyHeld
);

    localparam int PW = $clog2(SETTLE_CYCLES);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;
    logic [1:0]    r_col;
    logic [1:0]    w_col_next;
    logic          w_phase_last;
    logic          w_capture;

    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [15:0]   r_image;
    logic [15:0]   r_prev;
    logic [15:0]   r_stable;
    logic [15:0]   r_stable_d;
    logic [MW-1:0] r_match;
    logic [MW-1:0] w_match_next;
    logic          r_scan_done;
    logic          w_one_hot;
    logic [3:0]    w_index;

    assign w_phase_last = (r_phase == PW'(SETTLE_CYCLES - 1));

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_BLANK;
            r_phase <= '0;
            r_col   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_col   <= w_col_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase + 1'b1;
        w_col_next   = r_col;
        w_capture    = 1'b0;
        ColOut       = 4'b0000;
        case (r_state)
            ST_BLANK: begin
                if (w_phase_last) begin
                    w_state_next = ST_DRIVE;
                    w_phase_next = '0;
                end
            end
            ST_DRIVE: begin
                ColOut = 4'b0001 << r_col;
                if (w_phase_last) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_BLANK;
                    w_phase_next = '0;
                    w_col_next   = r_col + 2'd1;
                end
            end
            default: begin
                w_state_next = ST_BLANK;
                w_phase_next = '0;
            end
        endcase
    end

    // Two-flop synchronizer; only r_row_s2 is ever sampled.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_row_s1 <= 4'h0;
            r_row_s2 <= 4'h0;
        end else begin
            r_row_s1 <= RowIn;
            r_row_s2 <= r_row_s1;
        end
    end

    // Image slice for a column is written only from that column's last drive cycle,
    // so blank-phase row noise never reaches the image.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_image     <= 16'h0;
            r_scan_done <= 1'b0;
        end else begin
            if (w_capture) begin
                r_image[{r_col, 2'b00} +: 4] <= r_row_s2;
            end
            r_scan_done <= w_capture && (r_col == 2'd3);
        end
    end

    // Saturating count of identical consecutive images.
    always_comb begin
        w_match_next = {{(MW-1){1'b0}}, 1'b1};
        if (r_image == r_prev) begin
            w_match_next = (r_match == MW'(DEBOUNCE_SCANS)) ? r_match : r_match + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_prev   <= 16'h0;
            r_stable <= 16'h0;
            r_match  <= '0;
        end else if (r_scan_done) begin
            r_match <= w_match_next;
            r_prev  <= r_image;
            if ((w_match_next == MW'(DEBOUNCE_SCANS)) && (r_image != r_stable)) begin
                r_stable <= r_image;
            end
        end
    end

    assign w_one_hot = (r_stable != 16'h0) && ((r_stable & (r_stable - 16'd1)) == 16'h0);

    always_comb begin
        w_index = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_stable[i]) begin
                w_index = 4'(i);
            end
        end
    end

    // Events fire only on a zero -> single-bit transition of the stable image,
    // so multi-key chords and partial releases never produce a press.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_stable_d <= 16'h0;
            KeyValid   <= 1'b0;
            KeyCode    <= 4'h0;
            KeyHeld    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            KeyValid   <= 1'b0;
            KeyHeld    <= (r_stable != 16'h0);
            if ((r_stable != r_stable_d) && (r_stable_d == 16'h0) && w_one_hot) begin
                KeyValid <= 1'b1;
                KeyCode  <= w_index;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - scoreboard bench for keypad_matrix_scanner

module tb_keypad_matrix_scanner;

    localparam int DB   = 3;
    localparam int SCAN = 32;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic       KeyValid;
    logic [3:0] KeyCode;
    logic       KeyHeld;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  junk = 4'h0;
    int          cyc = 0;
    int          k_scan = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [3:0] code;
        int         scan;
    } ev_t;
    ev_t q[$];

    logic [15:0] m_prev;
    logic [15:0] m_stable;
    int          m_match;
    logic [3:0]  m_code;

    keypad_matrix_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(DB)) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .RowIn    (RowIn),
        .ColOut   (ColOut),
        .KeyValid (KeyValid),
        .KeyCode  (KeyCode),
        .KeyHeld  (KeyHeld)
    );

    always #5 Clk = ~Clk;

    // Physical matrix: rows show the pressed keys of the driven column; when no
    // column is driven the rows carry random noise that must never be imaged.
    always_comb begin
        case (ColOut)
            4'b0001: RowIn = pressed[3:0];
            4'b0010: RowIn = pressed[7:4];
            4'b0100: RowIn = pressed[11:8];
            4'b1000: RowIn = pressed[15:12];
            default: RowIn = junk;
        endcase
    end

    always @(posedge Clk) begin
        junk <= 4'($urandom);
        if (!nReset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_col(input int c);
        int off;
        off = c % SCAN;
        if ((off % 8) < 4) return 4'b0000;
        return 4'(1 << (off / 8));
    endfunction

    // Column drive pattern and event scoreboard.
    always @(negedge Clk) begin
        if (nReset) begin
            check("colout", ColOut, exp_col(cyc));
            if (KeyValid) begin
                if (q.size() == 0) begin
                    check("unexpected_keyvalid", 1, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("keycode", KeyCode, e.code);
                    check("event_scan", cyc / SCAN, e.scan);
                    check("event_offset_le3", (cyc % SCAN) <= 3, 1);
                end
            end
        end
    end

    task automatic model_reset();
        m_prev   = 16'h0;
        m_stable = 16'h0;
        m_match  = 0;
        m_code   = 4'h0;
        q.delete();
    endtask

    task automatic model_tick(input logic [15:0] img);
        int idx;
        if (img == m_prev) m_match = (m_match >= DB) ? DB : m_match + 1;
        else               m_match = 1;
        m_prev = img;
        if (m_match == DB && img != m_stable) begin
            if (m_stable == 16'h0 && $countones(img) == 1) begin
                idx = 0;
                for (int i = 0; i < 16; i++) if (img[i]) idx = i;
                m_code = 4'(idx);
                q.push_back('{4'(idx), k_scan + 1});
            end
            m_stable = img;
        end
    endtask

    task automatic run_scan(input logic [15:0] p);
        pressed = p;
        repeat (8) @(negedge Clk);
        check("keyheld", KeyHeld, m_stable != 16'h0);
        check("keycode_hold", KeyCode, m_code);
        repeat (SCAN - 8) @(negedge Clk);
        model_tick(p);
        k_scan++;
    endtask

    task automatic scans(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) run_scan(p);
    endtask

    task automatic reset_mid(input int off, input logic [15:0] p);
        pressed = p;
        repeat (off) @(negedge Clk);
        if (off == 20) check("colout_before_reset", ColOut, 4'b0100);
        #2 nReset = 1'b0;
        #1;
        check("rst_colout", ColOut, 4'b0000);
        check("rst_keyvalid", KeyValid, 1'b0);
        check("rst_keyheld", KeyHeld, 1'b0);
        check("rst_keycode", KeyCode, 4'h0);
        model_reset();
        pressed = 16'h0;
        repeat (3) @(negedge Clk);
        nReset = 1'b1;
        k_scan = 0;
    endtask

    initial begin
        logic [15:0] p;
        int          r;
        model_reset();
        repeat (3) @(negedge Clk);
        #1;
        check("init_colout", ColOut, 4'b0000);
        check("init_keyvalid", KeyValid, 1'b0);
        check("init_keycode", KeyCode, 4'h0);
        check("init_keyheld", KeyHeld, 1'b0);
        @(negedge Clk);
        nReset = 1'b1;

        scans(16'h0000, 10);                    // idle
        scans(16'h0040, 10);                    // single press, key 6
        scans(16'h0000, 4);
        for (int i = 0; i < 5; i++) begin       // bounce on key C
            scans(16'h1000, 2);
            scans(16'h0000, 1);
        end
        scans(16'h1000, 4);
        scans(16'h0000, 4);
        scans(16'h0201, 4);                     // multi-key chord
        scans(16'h0001, 4);                     // partial release
        scans(16'h0000, 4);
        scans(16'h0200, 4);                     // re-arm on key 9
        scans(16'h0000, 4);
        scans(16'h0200, 4);
        scans(16'h0000, 4);

        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      p = 16'h0;
            else if (r < 3)  p = 16'(1 << $urandom_range(0, 15));
            else             p = 16'($urandom);
            scans(p, $urandom_range(1, 5));
        end
        scans(16'h0000, 4);

        scans(16'h0200, 2);                     // reset while column 2 is driven
        reset_mid(20, 16'h0200);
        scans(16'h0000, 4);
        scans(16'h0200, 3);                     // reset one cycle before pending event
        reset_mid(1, 16'h0200);
        scans(16'h0000, 4);

        check("pending_events", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
